// File: rtl/feature_threshold_sched.sv
// feature_threshold_sched: shares one signed multiplier/comparator among six feature
// engines (ll, ne, ps, theta, alpha, beta). Each channel's feature is compared against
// base*scale; per-channel decisions feed an N-of-6 detection flag.
// Optional: define THRESH_SCALE_CFG_EN to add a runtime scale-write port.
module feature_threshold_sched #(
   parameter int unsigned               SCALE_W = 16,
   parameter logic signed [SCALE_W-1:0] S0      = '0,
   parameter logic signed [SCALE_W-1:0] S1      = '0,
   parameter logic signed [SCALE_W-1:0] S2      = '0,
   parameter logic signed [SCALE_W-1:0] S3      = '0,
   parameter logic signed [SCALE_W-1:0] S4      = '0,
   parameter logic signed [SCALE_W-1:0] S5      = '0,
   parameter int unsigned               DET_MIN = 3
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      en,
   input  logic                      clr,
   input  logic [5:0]                feat_valid,
   input  logic [6*72-1:0]           feat_out,
   input  logic [6*50-1:0]           feat_base,
`ifdef THRESH_SCALE_CFG_EN
   input  logic                      cfg_we,
   input  logic [2:0]                cfg_addr,
   input  logic signed [SCALE_W-1:0] cfg_data,
`endif
   output logic [5:0]                bin_out,
   output logic [5:0]                bin_strobe,
   output logic [5:0]                overrun,
   output logic [2:0]                det_count,
   output logic                      det_flag,
   output logic                      busy
);

   localparam int unsigned NCH     = 6;
   localparam int unsigned OUT_W   = 72;
   localparam int unsigned BASE_W  = 50;
   localparam int unsigned OUT0_W  = 41;
   localparam int unsigned BASE0_W = 34;
   localparam int unsigned PROD_W  = BASE_W + SCALE_W;
   localparam int unsigned CMP_W   = ((OUT_W > PROD_W) ? OUT_W : PROD_W) + 1;

   logic signed [OUT_W-1:0]   cap_out  [NCH];
   logic signed [BASE_W-1:0]  cap_base [NCH];
   logic signed [OUT_W-1:0]   in_out   [NCH];
   logic signed [BASE_W-1:0]  in_base  [NCH];
   logic signed [SCALE_W-1:0] scale    [NCH];

   logic [NCH-1:0] pending, pending_n, overrun_n, gnt_mask, bin_out_n, strobe_n;
   logic [2:0]     ptr, ptr_n, gnt_idx;
   logic [3:0]     arb_idx;
   logic           gnt_v, cmp, s1_v_n, busy_n;

   logic                      s0_v, s1_v;
   logic [2:0]                s0_tag, s1_tag;
   logic signed [OUT_W-1:0]   s0_out, s1_out, sel_out;
   logic signed [BASE_W-1:0]  s0_base, sel_base;
   logic signed [SCALE_W-1:0] s0_scale, sel_scale;
   logic signed [PROD_W-1:0]  s1_prod;
   logic                      unused_ch0_hi;

   function automatic logic [2:0] popcnt6(input logic [5:0] v);
      logic [2:0] c;
      c = '0;
      for (int i = 0; i < 6; i++) c = c + 3'(v[i]);
      return c;
   endfunction

   // Input slicing; channel 0 carries narrower fields that are sign-extended
   always_comb begin
      for (int i = 0; i < NCH; i++) begin
         in_out[i]  = feat_out[OUT_W*i +: OUT_W];
         in_base[i] = feat_base[BASE_W*i +: BASE_W];
      end
      in_out[0]  = OUT_W'($signed(feat_out[OUT0_W-1:0]));
      in_base[0] = BASE_W'($signed(feat_base[BASE0_W-1:0]));
   end

   assign unused_ch0_hi = ^{feat_out[OUT_W-1:OUT0_W], feat_base[BASE_W-1:BASE0_W]};

`ifdef THRESH_SCALE_CFG_EN
   // Runtime-writable scale table; addresses 6 and 7 fall through untouched
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         scale[0] <= S0; scale[1] <= S1; scale[2] <= S2;
         scale[3] <= S3; scale[4] <= S4; scale[5] <= S5;
      end else if (cfg_we) begin
         for (int i = 0; i < NCH; i++)
            if (cfg_addr == 3'(i)) scale[i] <= cfg_data;
      end
   end
`else
   // Fixed scale table
   always_comb begin
      scale[0] = S0; scale[1] = S1; scale[2] = S2;
      scale[3] = S3; scale[4] = S4; scale[5] = S5;
   end
`endif

   // Round-robin arbiter: lowest offset from ptr wins, loop runs high-to-low offset
   always_comb begin
      gnt_v   = 1'b0;
      gnt_idx = '0;
      arb_idx = '0;
      for (int k = NCH - 1; k >= 0; k--) begin
         arb_idx = 4'(ptr) + 4'(k);
         if (arb_idx >= 4'(NCH)) arb_idx = arb_idx - 4'(NCH);
         if (en && !clr && pending[arb_idx[2:0]]) begin
            gnt_v   = 1'b1;
            gnt_idx = arb_idx[2:0];
         end
      end
      gnt_mask = gnt_v ? (6'(1) << gnt_idx) : '0;
   end

   // Operand mux for the granted channel (reads captures before this edge's overwrite)
   always_comb begin
      sel_out   = '0;
      sel_base  = '0;
      sel_scale = '0;
      for (int i = 0; i < NCH; i++) begin
         if (gnt_idx == 3'(i)) begin
            sel_out   = cap_out[i];
            sel_base  = cap_base[i];
            sel_scale = scale[i];
         end
      end
   end

   // Next-state: pending/overrun bookkeeping, pointer advance, compare stage, clear
   always_comb begin
      pending_n = (pending & ~gnt_mask) | feat_valid;
      overrun_n = overrun | (feat_valid & pending & ~gnt_mask);
      ptr_n     = ptr;
      bin_out_n = bin_out;
      strobe_n  = '0;
      s1_v_n    = s0_v;
      cmp       = CMP_W'(s1_out) >= CMP_W'(s1_prod);
      if (gnt_v) ptr_n = (gnt_idx == 3'(NCH - 1)) ? 3'd0 : gnt_idx + 3'd1;
      if (s1_v) begin
         for (int i = 0; i < NCH; i++) begin
            if (s1_tag == 3'(i)) begin
               bin_out_n[i] = cmp;
               strobe_n[i]  = 1'b1;
            end
         end
      end
      if (clr) begin
         pending_n = '0;
         overrun_n = '0;
         ptr_n     = '0;
         bin_out_n = '0;
         strobe_n  = '0;
         s1_v_n    = 1'b0;
      end
      busy_n = (|pending_n) | gnt_v | s1_v_n;
   end

   // State, capture, pipeline and output registers
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < NCH; i++) begin
            cap_out[i]  <= '0;
            cap_base[i] <= '0;
         end
         pending    <= '0;
         overrun    <= '0;
         ptr        <= '0;
         s0_v       <= 1'b0;
         s0_tag     <= '0;
         s0_out     <= '0;
         s0_base    <= '0;
         s0_scale   <= '0;
         s1_v       <= 1'b0;
         s1_tag     <= '0;
         s1_out     <= '0;
         s1_prod    <= '0;
         bin_out    <= '0;
         bin_strobe <= '0;
         det_count  <= '0;
         det_flag   <= 1'b0;
         busy       <= 1'b0;
      end else begin
         if (!clr) begin
            for (int i = 0; i < NCH; i++) begin
               if (feat_valid[i]) begin
                  cap_out[i]  <= in_out[i];
                  cap_base[i] <= in_base[i];
               end
            end
         end
         pending    <= pending_n;
         overrun    <= overrun_n;
         ptr        <= ptr_n;
         s0_v       <= gnt_v;
         s0_tag     <= gnt_idx;
         s0_out     <= sel_out;
         s0_base    <= sel_base;
         s0_scale   <= sel_scale;
         s1_v       <= s1_v_n;
         s1_tag     <= s0_tag;
         s1_out     <= s0_out;
         s1_prod    <= PROD_W'(s0_base) * PROD_W'(s0_scale);
         bin_out    <= bin_out_n;
         bin_strobe <= strobe_n;
         det_count  <= clr ? 3'd0 : popcnt6(bin_out);
         det_flag   <= clr ? 1'b0 : (popcnt6(bin_out) >= 3'(DET_MIN));
         busy       <= busy_n;
      end
   end

endmodule

// File: tb/tb_feature_threshold_sched.sv
// Directed self-checking bench for feature_threshold_sched.
// Scales: S0=1 S1=2 S2=1 S3=-3 S4=1 S5=1, DET_MIN=3.
module tb_feature_threshold_sched;

   logic           clk = 1'b0;
   logic           rst, en, clr;
   logic [5:0]     feat_valid;
   logic [6*72-1:0] feat_out;
   logic [6*50-1:0] feat_base;
   logic [5:0]     bin_out, bin_strobe, overrun;
   logic [2:0]     det_count;
   logic           det_flag, busy;
`ifdef THRESH_SCALE_CFG_EN
   logic           cfg_we;
   logic [2:0]     cfg_addr;
   logic signed [15:0] cfg_data;
`endif

   int checks = 0;
   int errors = 0;
   int cnt;
   logic [5:0] exp_s;

   always #5 clk = ~clk;

   feature_threshold_sched #(
      .SCALE_W(16), .S0(16'sd1), .S1(16'sd2), .S2(16'sd1),
      .S3(-16'sd3), .S4(16'sd1), .S5(16'sd1), .DET_MIN(3)
   ) dut (
      .clk(clk), .rst(rst), .en(en), .clr(clr),
      .feat_valid(feat_valid), .feat_out(feat_out), .feat_base(feat_base),
`ifdef THRESH_SCALE_CFG_EN
      .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_data(cfg_data),
`endif
      .bin_out(bin_out), .bin_strobe(bin_strobe), .overrun(overrun),
      .det_count(det_count), .det_flag(det_flag), .busy(busy)
   );

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [71:0] got, input logic [71:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic set_ch(input int ch, input logic [71:0] o, input logic [49:0] b);
      feat_out[72*ch +: 72]  = o;
      feat_base[50*ch +: 50] = b;
   endtask

   task automatic fire(input logic [5:0] m);
      feat_valid = m;
      tick();
      feat_valid = '0;
   endtask

   // Single uncontended evaluation: strobe exactly 3 clocks after the capture edge
   task automatic eval(input int ch, input logic [71:0] o, input logic [49:0] b,
                       input logic exp_bit, input string tag);
      set_ch(ch, o, b);
      fire(6'(1) << ch);
      tick();
      check({tag, "_strobe_e1"}, 72'(bin_strobe), 72'(0));
      tick();
      check({tag, "_strobe_e2"}, 72'(bin_strobe), 72'(0));
      tick();
      check({tag, "_strobe_e3"}, 72'(bin_strobe), 72'(6'(1) << ch));
      check({tag, "_bin"}, 72'(bin_out[ch]), 72'(exp_bit));
   endtask

   initial begin
      rst = 1'b1; en = 1'b1; clr = 1'b0;
      feat_valid = '0; feat_out = '0; feat_base = '0;
`ifdef THRESH_SCALE_CFG_EN
      cfg_we = 1'b0; cfg_addr = '0; cfg_data = '0;
`endif
      repeat (2) tick();
      rst = 1'b0;
      tick();
      check("rst_bin_out", 72'(bin_out), 72'(0));
      check("rst_strobe", 72'(bin_strobe), 72'(0));
      check("rst_overrun", 72'(overrun), 72'(0));
      check("rst_det", 72'({det_count, det_flag}), 72'(0));
      check("rst_busy", 72'(busy), 72'(0));

      // ne: 20 >= 10*2 true, 19 >= 20 false
      eval(1, 72'(20), 50'(10), 1'b1, "ne_eq");
      eval(1, 72'(19), 50'(10), 1'b0, "ne_lt");
      // theta with negative scale: 5*-3 = -15
      eval(3, 72'(-15), 50'(5), 1'b1, "th_eq");
      eval(3, 72'(-16), 50'(5), 1'b0, "th_lt");
      // ll narrow fields, junk above bit 41/34 must be ignored: base -1 * 1 = -1
      eval(0, {31'h1234567, 41'h1FFFFFFFFFF}, {16'hBEEF, 34'h3FFFFFFFF}, 1'b1, "ll_neg_eq");
      eval(0, {31'h1234567, 41'h1FFFFFFFFFE}, {16'hBEEF, 34'h3FFFFFFFF}, 1'b0, "ll_neg_lt");

      // All six at once from ptr=0: strobes 0..5 on consecutive cycles
      clr = 1'b1; tick(); clr = 1'b0;
      set_ch(0, 72'(3), 50'(3));
      set_ch(1, 72'(19), 50'(10));
      set_ch(2, 72'(5), 50'(4));
      set_ch(3, 72'(-16), 50'(5));
      set_ch(4, 72'(0), 50'(0));
      set_ch(5, 72'(6), 50'(7));
      fire(6'h3F);
      for (int k = 1; k <= 8; k++) begin
         tick();
         exp_s = '0;
         if (k >= 3) exp_s = 6'(1) << (k - 3);
         check($sformatf("all6_strobe_e%0d", k), 72'(bin_strobe), 72'(exp_s));
         if (k == 7) check("all6_busy_e7", 72'(busy), 72'(1));
      end
      check("all6_bin", 72'(bin_out), 72'(6'b010101));
      check("all6_busy_end", 72'(busy), 72'(0));

      // Detection: channels 0,1,2 all true, flag one clock after the third bin_out
      clr = 1'b1; tick(); clr = 1'b0;
      set_ch(0, 72'(3), 50'(3));
      set_ch(1, 72'(20), 50'(10));
      set_ch(2, 72'(5), 50'(4));
      fire(6'b000111);
      for (int k = 1; k <= 6; k++) begin
         tick();
         if (k == 5) begin
            check("det_bin_e5", 72'(bin_out), 72'(6'b000111));
            check("det_cnt_e5", 72'(det_count), 72'(2));
            check("det_flag_e5", 72'(det_flag), 72'(0));
         end
         if (k == 6) begin
            check("det_cnt_e6", 72'(det_count), 72'(3));
            check("det_flag_e6", 72'(det_flag), 72'(1));
         end
      end

      // Valid on the grant cycle: old data evaluated, new data queued, no overrun
      clr = 1'b1; tick(); clr = 1'b0;
      set_ch(1, 72'(20), 50'(10));
      fire(6'b000010);
      set_ch(1, 72'(19), 50'(10));
      fire(6'b000010);
      check("same_ovr", 72'(overrun), 72'(0));
      tick();
      tick();
      check("same_strobe_a", 72'(bin_strobe), 72'(6'b000010));
      check("same_bin_a", 72'(bin_out[1]), 72'(1));
      tick();
      check("same_strobe_b", 72'(bin_strobe), 72'(6'b000010));
      check("same_bin_b", 72'(bin_out[1]), 72'(0));
      check("same_ovr_end", 72'(overrun), 72'(0));

      // Overrun: two ps pulses while en=0; only the newer (false) one is evaluated
      en = 1'b0;
      set_ch(2, 72'(100), 50'(4));
      fire(6'b000100);
      set_ch(2, 72'(3), 50'(4));
      fire(6'b000100);
      check("ovr_flag", 72'(overrun), 72'(6'b000100));
      tick();
      check("ovr_hold_busy", 72'(busy), 72'(1));
      en = 1'b1;
      cnt = 0;
      repeat (6) begin
         tick();
         cnt += int'(bin_strobe[2]);
      end
      check("ovr_strobes", 72'(cnt), 72'(1));
      check("ovr_bin", 72'(bin_out[2]), 72'(0));

      // Clear with a simultaneous valid: everything to 0, the valid is dropped
      eval(0, 72'(3), 50'(3), 1'b1, "pre_clr");
      tick();
      set_ch(0, 72'(3), 50'(3));
      clr = 1'b1;
      fire(6'b000001);
      clr = 1'b0;
      check("clr_bin", 72'(bin_out), 72'(0));
      check("clr_ovr", 72'(overrun), 72'(0));
      check("clr_det", 72'({det_count, det_flag}), 72'(0));
      check("clr_busy", 72'(busy), 72'(0));
      cnt = 0;
      repeat (4) begin
         tick();
         cnt += int'(|bin_strobe);
      end
      check("clr_drop", 72'(cnt), 72'(0));

      // Async reset mid-evaluation: no strobe afterwards
      set_ch(1, 72'(20), 50'(10));
      fire(6'b000010);
      tick();
      #2 rst = 1'b1;
      #1 rst = 1'b0;
      cnt = 0;
      repeat (4) begin
         tick();
         cnt += int'(|bin_strobe);
      end
      check("rst_mid_strobes", 72'(cnt), 72'(0));
      check("rst_mid_bin", 72'(bin_out), 72'(0));

`ifdef THRESH_SCALE_CFG_EN
      // Scale write: alpha scale -1 makes -7 >= 7*-1 true; addr 7 write ignored
      cfg_we = 1'b1; cfg_addr = 3'd4; cfg_data = -16'sd1;
      tick();
      cfg_we = 1'b0;
      eval(4, 72'(-7), 50'(7), 1'b1, "cfg_al");
      cfg_we = 1'b1; cfg_addr = 3'd7; cfg_data = 16'sd5;
      tick();
      cfg_we = 1'b0;
      eval(4, 72'(-7), 50'(7), 1'b1, "cfg_a7_al");
      eval(0, 72'(0), 50'(-1), 1'b1, "cfg_a7_ll");
`endif

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
